// File: rtl/sdhci_rsp_pkg.sv
// Shared types and constants for the SD command-response receive path.
package sdhci_rsp_pkg;

  typedef enum logic [1:0] {
    RX_IDLE       = 2'd0,
    RX_WAIT_START = 2'd1,
    RX_RECEIVE    = 2'd2,
    RX_DONE       = 2'd3
  } rsp_rx_state_e;

  localparam int unsigned RspLenShort    = 48;
  localparam int unsigned RspLenLong     = 136;
  localparam int unsigned RspLongHdrBits = 8;
  localparam logic [6:0]  Crc7Poly       = 7'h09;

  // One serial CRC7 step, MSb-first data, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic data);
    return {crc[5:0], 1'b0} ^ ((data ^ crc[6]) ? Crc7Poly : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_ser.sv
// Serial CRC7 accumulator: one data bit per enable, synchronous clear.
module crc7_ser
  import sdhci_rsp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       data,
  output logic [6:0] crc
);

  // CRC register; clear wins over a simultaneous enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc7_step(crc, data);
    end
  end

endmodule

// File: rtl/sd_rsp_rx_ctrl.sv
// SD command-response receiver sequencer: start-bit hunt, shift enables,
// on-the-fly CRC7, end-bit and NCR timeout checking.
module sd_rsp_rx_ctrl
  import sdhci_rsp_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sd_strobe_i,
  input  logic cmd_i,
  input  logic start_i,
  input  logic long_rsp_i,
  input  logic crc_chk_i,
  input  logic abort_i,
  output logic shift_en_o,
  output logic par_en_o,
  output logic busy_o,
  output logic done_o,
  output logic crc_err_o,
  output logic end_err_o,
  output logic timeout_o
);

  localparam int unsigned BitCntW = $clog2(RspLenLong + 1);
  localparam int unsigned ToCntW  = $clog2(TimeoutCycles + 1);

  localparam logic [BitCntW-1:0] BitMax    = BitCntW'(RspLenLong);
  localparam logic [BitCntW-1:0] LastShort = BitCntW'(RspLenShort - 1);
  localparam logic [BitCntW-1:0] LastLong  = BitCntW'(RspLenLong - 1);
  localparam logic [BitCntW-1:0] HdrBits   = BitCntW'(RspLongHdrBits);
  // CRC field (7) plus end bit (1) trail the protected region.
  localparam logic [BitCntW-1:0] TailBits  = BitCntW'(8);
  localparam logic [ToCntW-1:0]  ToLast    = ToCntW'(TimeoutCycles - 1);
  localparam logic [ToCntW-1:0]  ToMax     = ToCntW'(TimeoutCycles);

  rsp_rx_state_e state, state_next;

  logic               long_q;
  logic               chk_q;
  logic [BitCntW-1:0] bit_cnt;
  logic [ToCntW-1:0]  to_cnt;
  logic [6:0]         crc;

  logic               accept;
  logic               hunt_idle;
  logic               crc_en;
  logic [BitCntW-1:0] last_idx;
  logic [BitCntW-1:0] crc_lo;
  logic [BitCntW-1:0] crc_hi;
  logic               in_crc;
  logic               in_cmp;
  logic               is_last;
  logic [2:0]         cmp_idx;

  function automatic logic [ToCntW-1:0] sat_inc_to(input logic [ToCntW-1:0] v);
    return (v == ToMax) ? v : v + 1'b1;
  endfunction

  // bit_cnt holds the index (from the MSb) of the bit sampled on this strobe.
  assign accept    = (state == RX_IDLE) && start_i && !abort_i;
  assign hunt_idle = (state == RX_WAIT_START) && sd_strobe_i && cmd_i;
  assign last_idx  = long_q ? LastLong : LastShort;
  assign crc_lo    = long_q ? HdrBits : '0;
  assign crc_hi    = last_idx - TailBits;
  assign in_crc    = (bit_cnt >= crc_lo) && (bit_cnt <= crc_hi);
  assign in_cmp    = (bit_cnt > crc_hi) && (bit_cnt < last_idx);
  assign is_last   = (bit_cnt == last_idx);
  // CRC bit 6 is transmitted first, so the compare index counts down to 0.
  assign cmp_idx   = 3'(last_idx - BitCntW'(1) - bit_cnt);
  assign crc_en    = shift_en_o && in_crc;

  crc7_ser u_crc7 (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (accept),
    .enable (crc_en),
    .data   (cmd_i),
    .crc    (crc)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state outputs; abort overrides every transition.
  always_comb begin
    state_next = state;
    shift_en_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (start_i) state_next = RX_WAIT_START;
      end
      RX_WAIT_START: begin
        busy_o = 1'b1;
        if (sd_strobe_i) begin
          if (!cmd_i) begin
            shift_en_o = 1'b1;
            state_next = RX_RECEIVE;
          end else if (to_cnt == ToLast) begin
            state_next = RX_DONE;
          end
        end
      end
      RX_RECEIVE: begin
        busy_o = 1'b1;
        if (sd_strobe_i) begin
          shift_en_o = 1'b1;
          if (is_last) state_next = RX_DONE;
        end
      end
      RX_DONE: begin
        done_o     = 1'b1;
        state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
    if (abort_i) state_next = RX_IDLE;
  end

  // Counters, latched options and sticky status; abort freezes the flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      long_q    <= 1'b0;
      chk_q     <= 1'b0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      crc_err_o <= 1'b0;
      end_err_o <= 1'b0;
      timeout_o <= 1'b0;
      par_en_o  <= 1'b0;
    end else if (accept) begin
      long_q    <= long_rsp_i;
      chk_q     <= crc_chk_i;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      crc_err_o <= 1'b0;
      end_err_o <= 1'b0;
      timeout_o <= 1'b0;
      par_en_o  <= 1'b0;
    end else begin
      if (shift_en_o && (bit_cnt != BitMax)) bit_cnt <= bit_cnt + 1'b1;
      if (hunt_idle) to_cnt <= sat_inc_to(to_cnt);
      if (abort_i) begin
        par_en_o <= 1'b0;
      end else begin
        if (hunt_idle && (to_cnt == ToLast)) timeout_o <= 1'b1;
        if (shift_en_o && in_cmp && chk_q && (cmd_i != crc[cmp_idx])) crc_err_o <= 1'b1;
        if (shift_en_o && is_last && !cmd_i) end_err_o <= 1'b1;
        if ((state == RX_RECEIVE) && sd_strobe_i && is_last) par_en_o <= 1'b1;
      end
    end
  end

endmodule
